imem_loader: RTL and testbench

Writable instruction store plus serial program loader for the 16-bit single-cycle MIPS core. It accepts a byte stream (valid/ready) carrying a length header, 16-bit instruction words and an XOR checksum, and writes the words into a 16-entry instruction RAM. The core's fetch path reads the same RAM combinationally by PC. `cpu_hold` stalls the core while a load is in progress.

---
 rtl/imem_loader_pkg.sv | 24 ++
 rtl/imem_loader_if.sv | 25 ++
 rtl/imem_loader_ram.sv | 49 ++++
 rtl/imem_loader.sv | 149 ++++++++++++++
 tb/tb_imem_loader.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/imem_loader_pkg.sv
// imem_pkg: shared types and sizing for the instruction store and its loader.
//   ldr_state_t : loader FSM state encoding
//   IMEM_DEPTH  : number of 16-bit instruction words
//   IMEM_AW     : word address width, log2(IMEM_DEPTH)
//   INSTR_W     : instruction word width
//   BYTE_W      : width of the load stream
package imem_pkg;

    localparam int IMEM_DEPTH = 16;
    localparam int IMEM_AW    = 4;
    localparam int INSTR_W    = 16;
    localparam int BYTE_W     = 8;

    typedef enum logic [2:0] {
        IDLE,
        LEN,
        HI,
        LO,
        CSUM,
        DONE,
        ERR
    } ldr_state_t;

endpackage

// File: rtl/imem_loader_if.sv
// imem_loader_if: valid/ready byte stream that carries a program image.
//   byte_in    : stream data, driven by the source
//   byte_valid : byte_in is valid, driven by the source
//   byte_ready : sink can accept a byte this cycle
// A byte transfers on any rising clock edge with byte_valid && byte_ready.
interface imem_loader_if;
    import imem_pkg::*;

    logic [BYTE_W-1:0] byte_in;
    logic              byte_valid;
    logic              byte_ready;

    modport master (
        output byte_in,
        output byte_valid,
        input  byte_ready
    );

    modport slave (
        input  byte_in,
        input  byte_valid,
        output byte_ready
    );

endinterface

// File: rtl/imem_loader_ram.sv
// imem_ram: DEPTH x 16-bit instruction RAM.
//   clk, rst_n  : clock; synchronous active-low reset clears every word
//   we, waddr,
//   wdata       : synchronous write port
//   p_in        : PC byte address from the core (bit 0 ignored)
//   instruction : combinational read; words past DEPTH read as zero
module imem_ram
    import imem_pkg::*;
#(
    parameter int DEPTH = IMEM_DEPTH,
    parameter int AW    = IMEM_AW
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               we,
    input  logic [AW-1:0]      waddr,
    input  logic [INSTR_W-1:0] wdata,
    input  logic [15:0]        p_in,
    output logic [INSTR_W-1:0] instruction
);

    logic [INSTR_W-1:0] mem [DEPTH];
    logic [14:0]        widx;
    logic               unused_pc_lsb;

    // Reset wipes the whole store so a core released after an aborted
    // load fetches zeros rather than a partial program.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Instructions are halfword aligned, so the PC byte address drops its LSB.
    assign widx          = p_in[15:1];
    assign unused_pc_lsb = p_in[0];

    always_comb begin
        instruction = '0;
        if (32'(widx) < DEPTH) begin
            instruction = mem[widx[AW-1:0]];
        end
    end

endmodule

// File: rtl/imem_loader.sv
// imem_loader: writable instruction store plus serial program loader.
//   clk, rst_n  : clock; synchronous active-low reset
//   start       : one-cycle pulse that begins a load (ignored while busy)
//   bus         : byte stream sink (len, {hi,lo} x N, xor checksum)
//   p_in        : PC byte address from the core
//   instruction : fetched word, combinational
//   busy        : a load is in progress
//   cpu_hold    : core stall request, identical to busy
//   done        : sticky, last load completed with a good checksum
//   err         : sticky, last load failed (bad length or checksum)
//   word_count  : words written by the current or last load
module imem_loader
    import imem_pkg::*;
#(
    parameter int DEPTH = IMEM_DEPTH,
    parameter int AW    = IMEM_AW
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    imem_loader_if.slave       bus,
    input  logic [15:0]        p_in,
    output logic [INSTR_W-1:0] instruction,
    output logic               busy,
    output logic               cpu_hold,
    output logic               done,
    output logic               err,
    output logic [AW:0]        word_count
);

    ldr_state_t        state;
    logic              byte_ready_q;
    logic [AW-1:0]     addr;
    logic [AW:0]       len;
    logic [BYTE_W-1:0] hi_byte;
    logic [BYTE_W-1:0] csum;
    logic              xfer;
    logic              we;

    assign bus.byte_ready = byte_ready_q;
    assign xfer           = bus.byte_valid && byte_ready_q;

    // The LO byte completes a word; it is written straight from the bus so
    // the word is readable on the very next cycle.
    assign we = xfer && (state == LO);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            byte_ready_q <= 1'b0;
            busy         <= 1'b0;
            cpu_hold     <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
            word_count   <= '0;
            addr         <= '0;
            len          <= '0;
            hi_byte      <= '0;
            csum         <= '0;
        end else begin
            case (state)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        state        <= LEN;
                        byte_ready_q <= 1'b1;
                        busy         <= 1'b1;
                        cpu_hold     <= 1'b1;
                        done         <= 1'b0;
                        err          <= 1'b0;
                        word_count   <= '0;
                        addr         <= '0;
                        csum         <= '0;
                    end
                end

                LEN: begin
                    if (xfer) begin
                        // Rejecting oversize lengths here is what keeps addr
                        // from ever wrapping onto already-loaded words.
                        if (bus.byte_in == '0 || 32'(bus.byte_in) > DEPTH) begin
                            state        <= ERR;
                            err          <= 1'b1;
                            byte_ready_q <= 1'b0;
                            busy         <= 1'b0;
                            cpu_hold     <= 1'b0;
                        end else begin
                            len   <= bus.byte_in[AW:0];
                            state <= HI;
                        end
                    end
                end

                HI: begin
                    if (xfer) begin
                        hi_byte <= bus.byte_in;
                        csum    <= csum ^ bus.byte_in;
                        state   <= LO;
                    end
                end

                LO: begin
                    if (xfer) begin
                        csum       <= csum ^ bus.byte_in;
                        addr       <= addr + 1'b1;
                        word_count <= word_count + 1'b1;
                        state      <= (word_count + 1'b1 == len) ? CSUM : HI;
                    end
                end

                CSUM: begin
                    if (xfer) begin
                        byte_ready_q <= 1'b0;
                        busy         <= 1'b0;
                        cpu_hold     <= 1'b0;
                        // Written words are left in place on a bad checksum.
                        if (bus.byte_in == csum) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= ERR;
                            err   <= 1'b1;
                        end
                    end
                end

                default: begin
                    state        <= IDLE;
                    byte_ready_q <= 1'b0;
                    busy         <= 1'b0;
                    cpu_hold     <= 1'b0;
                end
            endcase
        end
    end

    imem_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk         (clk),
        .rst_n       (rst_n),
        .we          (we),
        .waddr       (addr),
        .wdata       ({hi_byte, bus.byte_in}),
        .p_in        (p_in),
        .instruction (instruction)
    );

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;
    import imem_pkg::*;

    typedef logic [7:0] bq_t[$];

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] p_in = '0;
    logic [15:0] instruction;
    logic        busy, cpu_hold, done, err;
    logic [4:0]  word_count;

    imem_loader_if bus ();

    imem_loader dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .bus         (bus),
        .p_in        (p_in),
        .instruction (instruction),
        .busy        (busy),
        .cpu_hold    (cpu_hold),
        .done        (done),
        .err         (err),
        .word_count  (word_count)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: what the program store should contain and report.
    logic [15:0] ref_mem [IMEM_DEPTH];
    logic        ref_done, ref_err;
    int          ref_wc;

    task automatic model_reset();
        for (int i = 0; i < IMEM_DEPTH; i++) ref_mem[i] = '0;
        ref_done = 0; ref_err = 0; ref_wc = 0;
    endtask

    // Apply a whole stream: length header, N big-endian words, xor checksum.
    task automatic model_load(input bq_t q);
        int n;
        logic [7:0] x;
        n = int'(q[0]);
        ref_done = 0; ref_err = 0; ref_wc = 0;
        if (n == 0 || n > IMEM_DEPTH) begin
            ref_err = 1;
            return;
        end
        x = '0;
        for (int i = 0; i < n; i++) begin
            ref_mem[i] = {q[1+2*i], q[2+2*i]};
            x = x ^ q[1+2*i] ^ q[2+2*i];
        end
        ref_wc = n;
        if (q[2*n+1] == x) ref_done = 1; else ref_err = 1;
    endtask

    function automatic bq_t make_stream(input int n, input bit bad);
        bq_t q;
        logic [7:0] x, b;
        q.push_back(8'(n));
        x = '0;
        for (int i = 0; i < 2 * n; i++) begin
            b = 8'($urandom_range(0, 255));
            q.push_back(b);
            x ^= b;
        end
        q.push_back(bad ? ~x : x);
        return q;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 0; start = 0; bus.byte_valid = 0;
        repeat (2) @(negedge clk);
        rst_n = 1;
        model_reset();
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1;
        @(posedge clk);
        #1 start = 0;
    endtask

    // Offer one byte; returns at posedge+1 after it was accepted.
    task automatic push(input logic [7:0] b, input bit gaps);
        int n;
        n = 0;
        forever begin
            @(negedge clk);
            n++;
            if (n > 200) begin
                vectors++; miscompares++;
                $display("FAIL push_timeout byte_ready got 0 exp 1");
                bus.byte_valid = 0;
                return;
            end
            if (gaps && $urandom_range(0, 2) == 0) begin
                bus.byte_valid = 0;
                continue;
            end
            bus.byte_valid = 1;
            bus.byte_in = b;
            if (bus.byte_ready) break;
        end
        @(posedge clk);
        #1 bus.byte_valid = 0;
    endtask

    task automatic send_stream(input bq_t q, input bit gaps);
        foreach (q[i]) push(q[i], gaps);
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy got %b exp 0", busy); end
        vectors++; if (cpu_hold !== 1'b0) begin miscompares++; $display("FAIL rst_hold got %b exp 0", cpu_hold); end
        vectors++; if (bus.byte_ready !== 1'b0) begin miscompares++; $display("FAIL rst_ready got %b exp 0", bus.byte_ready); end
        vectors++; if ({done, err} !== 2'b00) begin miscompares++; $display("FAIL rst_done_err got %b exp 00", {done, err}); end
        vectors++; if (word_count !== 5'd0) begin miscompares++; $display("FAIL rst_wc got %0d exp 0", word_count); end
    endtask

    task automatic test_good_load();
        bq_t q;
        logic [15:0] pcs [5];
        logic [15:0] exps [5];
        q = '{8'h02, 8'h01, 8'h23, 8'h12, 8'h34, 8'h04};
        pcs  = '{16'd0, 16'd2, 16'd3, 16'd4, 16'd32};
        exps = '{16'h0123, 16'h1234, 16'h1234, 16'h0000, 16'h0000};
        model_load(q);
        pulse_start();
        vectors++; if ({busy, cpu_hold} !== 2'b11) begin miscompares++; $display("FAIL good_busy_rise got %b exp 11", {busy, cpu_hold}); end
        send_stream(q, 0);
        vectors++; if ({done, err} !== 2'b10) begin miscompares++; $display("FAIL good_done_err got %b exp 10", {done, err}); end
        vectors++; if ({busy, cpu_hold} !== 2'b00) begin miscompares++; $display("FAIL good_busy_fall got %b exp 00", {busy, cpu_hold}); end
        vectors++; if (word_count !== 5'd2) begin miscompares++; $display("FAIL good_wc got %0d exp 2", word_count); end
        for (int i = 0; i < 5; i++) begin
            p_in = pcs[i];
            #1;
            vectors++;
            if (instruction !== exps[i]) begin
                miscompares++;
                $display("FAIL good_rd pc=%0d got %h exp %h", pcs[i], instruction, exps[i]);
            end
        end
    endtask

    task automatic test_bad_csum();
        bq_t q;
        q = '{8'h02, 8'h01, 8'h23, 8'h12, 8'h34, 8'h05};
        model_load(q);
        pulse_start();
        send_stream(q, 0);
        vectors++; if ({done, err} !== 2'b01) begin miscompares++; $display("FAIL csum_done_err got %b exp 01", {done, err}); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL csum_busy got %b exp 0", busy); end
        p_in = 16'd2;
        #1;
        vectors++; if (instruction !== 16'h1234) begin miscompares++; $display("FAIL csum_rd2 got %h exp 1234", instruction); end
    endtask

    task automatic test_bad_len();
        logic [7:0] lens [3];
        bq_t q;
        lens = '{8'h00, 8'h11, 8'($urandom_range(17, 255))};
        for (int k = 0; k < 3; k++) begin
            q = '{lens[k]};
            model_load(q);
            pulse_start();
            push(lens[k], 0);
            vectors++; if ({done, err} !== {ref_done, ref_err}) begin miscompares++; $display("FAIL len%h_done_err got %b exp %b", lens[k], {done, err}, {ref_done, ref_err}); end
            vectors++; if ({busy, bus.byte_ready} !== 2'b00) begin miscompares++; $display("FAIL len%h_busy_ready got %b exp 00", lens[k], {busy, bus.byte_ready}); end
            vectors++; if (word_count !== 5'(ref_wc)) begin miscompares++; $display("FAIL len%h_wc got %0d exp %0d", lens[k], word_count, ref_wc); end
            for (int i = 0; i < IMEM_DEPTH; i++) begin
                p_in = 16'(2 * i);
                #1;
                vectors++;
                if (instruction !== ref_mem[i]) begin miscompares++; $display("FAIL len%h_rd[%0d] got %h exp %h", lens[k], i, instruction, ref_mem[i]); end
            end
        end
    endtask

    task automatic test_full_random();
        bq_t q;
        q = make_stream(IMEM_DEPTH, 0);
        model_load(q);
        pulse_start();
        foreach (q[i]) begin
            push(q[i], 1);
            if (i < q.size() - 1) begin
                vectors++;
                if (cpu_hold !== 1'b1) begin miscompares++; $display("FAIL full_hold byte %0d got %b exp 1", i, cpu_hold); end
            end
        end
        vectors++; if ({done, err, cpu_hold} !== 3'b100) begin miscompares++; $display("FAIL full_end done,err,hold got %b exp 100", {done, err, cpu_hold}); end
        vectors++; if (word_count !== 5'd16) begin miscompares++; $display("FAIL full_wc got %0d exp 16", word_count); end
        for (int i = 0; i < IMEM_DEPTH; i++) begin
            p_in = 16'(2 * i + int'($urandom_range(0, 1)));
            #1;
            vectors++;
            if (instruction !== ref_mem[i]) begin miscompares++; $display("FAIL full_rd[%0d] got %h exp %h", i, instruction, ref_mem[i]); end
        end
        p_in = 16'($urandom_range(32, 65535));
        #1;
        vectors++; if (instruction !== 16'h0000) begin miscompares++; $display("FAIL full_oob pc=%0d got %h exp 0000", p_in, instruction); end
    endtask

    task automatic test_reset_mid();
        bq_t q;
        q = make_stream(6, 0);
        pulse_start();
        for (int i = 0; i < 4; i++) push(q[i], 0);
        do_reset();
        #1;
        vectors++; if ({busy, cpu_hold, bus.byte_ready} !== 3'b000) begin miscompares++; $display("FAIL mid_rst busy,hold,ready got %b exp 000", {busy, cpu_hold, bus.byte_ready}); end
        for (int i = 0; i < IMEM_DEPTH; i++) begin
            p_in = 16'(2 * i);
            #1;
            vectors++;
            if (instruction !== ref_mem[i]) begin miscompares++; $display("FAIL mid_rd[%0d] got %h exp %h", i, instruction, ref_mem[i]); end
        end
    endtask

    task automatic test_ignored_start();
        bq_t q;
        int n;
        n = int'($urandom_range(3, 10));
        q = make_stream(n, 0);
        model_load(q);
        pulse_start();
        for (int i = 0; i < 4; i++) push(q[i], 0);
        pulse_start();
        for (int i = 4; i < q.size(); i++) push(q[i], 0);
        vectors++; if ({done, err} !== 2'b10) begin miscompares++; $display("FAIL ign_done_err got %b exp 10", {done, err}); end
        vectors++; if (word_count !== 5'(n)) begin miscompares++; $display("FAIL ign_wc got %0d exp %0d", word_count, n); end
        for (int i = 0; i < IMEM_DEPTH; i++) begin
            p_in = 16'(2 * i);
            #1;
            vectors++;
            if (instruction !== ref_mem[i]) begin miscompares++; $display("FAIL ign_rd[%0d] got %h exp %h", i, instruction, ref_mem[i]); end
        end
    endtask

    task automatic test_back_to_back();
        bq_t q;
        do_reset();
        q = make_stream(int'($urandom_range(4, 16)), 0);
        model_load(q);
        // start with a byte already valid in IDLE: that byte must not be taken
        @(negedge clk);
        start = 1; bus.byte_valid = 1; bus.byte_in = 8'h03;
        @(posedge clk);
        #1 start = 0; bus.byte_valid = 0;
        send_stream(q, 0);
        vectors++; if ({done, err} !== {ref_done, ref_err}) begin miscompares++; $display("FAIL b2b1_done_err got %b exp %b", {done, err}, {ref_done, ref_err}); end
        for (int k = 0; k < 2; k++) begin
            q = make_stream(int'($urandom_range(1, 16)), k == 1);
            model_load(q);
            pulse_start();
            send_stream(q, 0);
            vectors++; if ({done, err} !== {ref_done, ref_err}) begin miscompares++; $display("FAIL b2b%0d_done_err got %b exp %b", k + 2, {done, err}, {ref_done, ref_err}); end
            vectors++; if (word_count !== 5'(ref_wc)) begin miscompares++; $display("FAIL b2b%0d_wc got %0d exp %0d", k + 2, word_count, ref_wc); end
            for (int i = 0; i < IMEM_DEPTH; i++) begin
                p_in = 16'(2 * i);
                #1;
                vectors++;
                if (instruction !== ref_mem[i]) begin miscompares++; $display("FAIL b2b%0d_rd[%0d] got %h exp %h", k + 2, i, instruction, ref_mem[i]); end
            end
        end
    endtask

    initial begin
        bus.byte_in = '0;
        bus.byte_valid = 0;
        model_reset();
        test_reset();
        test_good_load();
        test_bad_csum();
        test_bad_len();
        test_full_random();
        test_reset_mid();
        test_ignored_start();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
